// File: rtl/sort4_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sort4_ctrl_pkg                                                  |
// | Purpose  : Shared constants, state encoding and compare-pair table for     |
// |            the four-operand sequential sorter.                             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package sort4_ctrl_pkg;

    localparam int unsigned c_WIDTH   = 4;
    localparam int unsigned c_N       = 4;
    localparam int unsigned c_NSTEPS  = 6;
    localparam int unsigned c_STEP_W  = 3;
    localparam int unsigned c_IDX_W   = 2;
    localparam int unsigned c_SWAP_W  = 3;

    localparam logic [c_STEP_W-1:0] c_LAST_STEP = 3'd5;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SORT = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Lower index of the adjacent pair compared at each step: a 3-pass bubble network.
    localparam logic [c_IDX_W-1:0] c_PAIR_LO [c_NSTEPS] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0};

    function automatic logic [c_IDX_W-1:0] pair_lo(input logic [c_STEP_W-1:0] step);
        if (step <= c_LAST_STEP) begin
            return c_PAIR_LO[step];
        end
        return '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/magcom4bit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : magcom4bit                                                      |
// | Purpose  : 4-bit unsigned magnitude comparator (equal / greater / less).   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module magcom4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       e,
    output logic       g,
    output logic       l
);

    assign e = (a == b);
    assign g = (a > b);
    assign l = (a < b);

endmodule
`default_nettype wire

// File: rtl/sort4_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sort4_ctrl                                                      |
// | Purpose  : Sorts four unsigned operands ascending with one shared          |
// |            comparator, one compare-exchange per cycle, fixed latency.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sort4_ctrl
    import sort4_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = c_WIDTH,
    parameter int unsigned N     = c_N
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [WIDTH-1:0]    a0,
    input  logic [WIDTH-1:0]    a1,
    input  logic [WIDTH-1:0]    a2,
    input  logic [WIDTH-1:0]    a3,
    output logic [WIDTH-1:0]    s0,
    output logic [WIDTH-1:0]    s1,
    output logic [WIDTH-1:0]    s2,
    output logic [WIDTH-1:0]    s3,
    output logic                busy,
    output logic                done,
    output logic [c_SWAP_W-1:0] swaps,
    output logic                eq_seen
);

    logic [1:0]             r_state;
    logic [c_STEP_W-1:0]    r_step;
    logic [WIDTH-1:0]       r_work [N];
    logic [c_SWAP_W-1:0]    r_swaps;
    logic                   r_eq;

    logic [c_IDX_W-1:0]     w_lo;
    logic [c_IDX_W-1:0]     w_hi;
    logic [WIDTH-1:0]       w_cmp_a;
    logic [WIDTH-1:0]       w_cmp_b;
    logic                   w_e;
    logic                   w_g;
    logic                   w_l;
    logic                   w_swap;
    logic [WIDTH-1:0]       w_next_work [N];
    logic [c_SWAP_W-1:0]    w_next_swaps;
    logic                   w_next_eq;

    assign w_lo    = pair_lo(r_step);
    assign w_hi    = w_lo + 2'd1;
    assign w_cmp_a = r_work[w_lo];
    assign w_cmp_b = r_work[w_hi];

    magcom4bit u_cmp (
        .a (w_cmp_a),
        .b (w_cmp_b),
        .e (w_e),
        .g (w_g),
        .l (w_l)
    );

    // Exchange only on a clean "greater"; ties never move, which keeps the sort stable.
    assign w_swap = w_g & ~w_e & ~w_l;

    always_comb begin
        w_next_work = r_work;
        if (w_swap) begin
            w_next_work[w_lo] = w_cmp_b;
            w_next_work[w_hi] = w_cmp_a;
        end
        w_next_swaps = r_swaps + {{(c_SWAP_W-1){1'b0}}, w_swap};
        w_next_eq    = r_eq | w_e;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_step  <= '0;
            for (int i = 0; i < N; i++) begin
                r_work[i] <= '0;
            end
            r_swaps <= '0;
            r_eq    <= 1'b0;
            s0      <= '0;
            s1      <= '0;
            s2      <= '0;
            s3      <= '0;
            swaps   <= '0;
            eq_seen <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_work[0] <= a0;
                        r_work[1] <= a1;
                        r_work[2] <= a2;
                        r_work[3] <= a3;
                        r_step    <= '0;
                        r_swaps   <= '0;
                        r_eq      <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= c_ST_SORT;
                    end
                end
                c_ST_SORT: begin
                    r_work  <= w_next_work;
                    r_swaps <= w_next_swaps;
                    r_eq    <= w_next_eq;
                    // The final step's exchange is folded straight into the result registers.
                    if (r_step == c_LAST_STEP) begin
                        s0      <= w_next_work[0];
                        s1      <= w_next_work[1];
                        s2      <= w_next_work[2];
                        s3      <= w_next_work[3];
                        swaps   <= w_next_swaps;
                        eq_seen <= w_next_eq;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= c_ST_DONE;
                    end else begin
                        r_step <= r_step + 3'd1;
                    end
                end
                c_ST_DONE: begin
                    done    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sort4_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sort4_ctrl                                                   |
// | Purpose  : Self-checking bench: directed table, held-start, mid-sort reset |
// |            and random operand sets against an independent reference.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_sort4_ctrl;

    localparam int c_W = 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [c_W-1:0] a0, a1, a2, a3;
    logic [c_W-1:0] s0, s1, s2, s3;
    logic           busy;
    logic           done;
    logic [2:0]     swaps;
    logic           eq_seen;

    int n_checks = 0;
    int n_fail   = 0;

    sort4_ctrl #(.WIDTH(4), .N(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a0      (a0),
        .a1      (a1),
        .a2      (a2),
        .a3      (a3),
        .s0      (s0),
        .s1      (s1),
        .s2      (s2),
        .s3      (s3),
        .busy    (busy),
        .done    (done),
        .swaps   (swaps),
        .eq_seen (eq_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;      // {a3,a2,a1,a0}
        logic [15:0] s;      // {s3,s2,s1,s0}
        int          swp;
        bit          eq;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] s_packed();
        return {s3, s2, s1, s0};
    endfunction

    task automatic set_a(input logic [15:0] v);
        a0 = v[3:0];
        a1 = v[7:4];
        a2 = v[11:8];
        a3 = v[15:12];
    endtask

    // Reference: rank-based sort, swap count = inversion count, eq = any duplicate.
    task automatic ref_sort(input logic [15:0] a, output logic [15:0] s, output int inv, output bit dup);
        logic [3:0] v [4];
        int rank;
        for (int i = 0; i < 4; i++) v[i] = a[i*4 +: 4];
        inv = 0;
        dup = 1'b0;
        s   = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = i + 1; j < 4; j++) begin
                if (v[i] > v[j]) inv++;
                if (v[i] == v[j]) dup = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            rank = 0;
            for (int j = 0; j < 4; j++) begin
                if (v[j] < v[i] || (v[j] == v[i] && j < i)) rank++;
            end
            s[rank*4 +: 4] = v[i];
        end
    endtask

    // Call with the DUT in IDLE, away from a clock edge. Latency counts the
    // accepting edge as 1, so done raised by the 7th edge gives lat=7.
    // Returns after the following edge, with the DUT back in IDLE.
    task automatic do_sort(input logic [15:0] v, input string tag, output int lat);
        set_a(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        chk({tag, "_busy_accept"}, {31'd0, busy}, 32'd1);
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 32'd7);
    endtask

    task automatic finish_pulse(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    endtask

    vec_t        tbl [6];
    logic [15:0] exp_s;
    int          exp_inv;
    bit          exp_dup;
    int          lat;
    int          pulses;
    logic [15:0] rv;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{16'hFC54, 16'hFC54, 0, 1'b0};   // (4,5,12,15) already sorted
        tbl[1] = '{16'h76DE, 16'hED76, 5, 1'b0};   // (14,13,6,7)
        tbl[2] = '{16'h45CF, 16'hFC54, 6, 1'b0};   // (15,12,5,4) fully reversed
        tbl[3] = '{16'h7777, 16'h7777, 0, 1'b1};   // all equal
        tbl[4] = '{16'h0F0F, 16'hFF00, 3, 1'b1};   // (15,0,15,0) extremes, no wrap
        tbl[5] = '{16'hE1F0, 16'hFE10, 2, 1'b0};   // (0,15,1,14)

        rst_n = 1'b0;
        start = 1'b0;
        set_a(16'h0000);
        #2;
        chk("reset_s",     {16'd0, s_packed()}, 32'd0);
        chk("reset_swaps", {29'd0, swaps}, 32'd0);
        chk("reset_eq",    {31'd0, eq_seen}, 32'd0);
        chk("reset_busy",  {31'd0, busy}, 32'd0);
        chk("reset_done",  {31'd0, done}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table; first start lands on the first edge after release.
        foreach (tbl[k]) begin
            do_sort(tbl[k].a, $sformatf("vec%0d", k), lat);
            chk($sformatf("vec%0d_s", k),     {16'd0, s_packed()}, {16'd0, tbl[k].s});
            chk($sformatf("vec%0d_swaps", k), {29'd0, swaps}, tbl[k].swp);
            chk($sformatf("vec%0d_eq", k),    {31'd0, eq_seen}, {31'd0, tbl[k].eq});
            finish_pulse($sformatf("vec%0d", k));
            chk($sformatf("vec%0d_hold_s", k), {16'd0, s_packed()}, {16'd0, tbl[k].s});
        end

        // Start held high across a whole sort; inputs changed after E2.
        set_a(16'h45CF);
        start  = 1'b1;
        pulses = 0;
        @(posedge clk);
        #1;
        chk("hold_busy_e0", {31'd0, busy}, 32'd1);
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) set_a(16'h0321);
            if (done) pulses++;
            if (k == 6) begin
                chk("hold_done_e6", {31'd0, done}, 32'd1);
                chk("hold_busy_done", {31'd0, busy}, 32'd0);
            end
        end
        chk("hold_one_pulse", pulses, 32'd1);
        chk("hold_s",      {16'd0, s_packed()}, 32'h0000FC54);
        chk("hold_swaps",  {29'd0, swaps}, 32'd6);
        chk("hold_idle_e7", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk("hold_restart_e8", {31'd0, busy}, 32'd1);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("hold2_latency", lat, 32'd7);
        chk("hold2_s",       {16'd0, s_packed()}, 32'h00003210);
        chk("hold2_swaps",   {29'd0, swaps}, 32'd3);
        finish_pulse("hold2");

        // Reset asserted during step 3 aborts the sort.
        set_a(16'h45CF);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_s",     {16'd0, s_packed()}, 32'd0);
        chk("abort_swaps", {29'd0, swaps}, 32'd0);
        chk("abort_eq",    {31'd0, eq_seen}, 32'd0);
        chk("abort_busy",  {31'd0, busy}, 32'd0);
        chk("abort_done",  {31'd0, done}, 32'd0);
        pulses = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        chk("abort_no_done", pulses, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_sort(16'h76DE, "after_rst", lat);
        chk("after_rst_s",     {16'd0, s_packed()}, 32'h0000ED76);
        chk("after_rst_swaps", {29'd0, swaps}, 32'd5);
        finish_pulse("after_rst");

        // Random operand sets against the reference model.
        for (int k = 0; k < 200; k++) begin
            rv = 16'($urandom);
            if (k % 5 == 0) rv[7:4] = rv[3:0];   // seed extra duplicates
            ref_sort(rv, exp_s, exp_inv, exp_dup);
            do_sort(rv, $sformatf("rnd%0d", k), lat);
            chk($sformatf("rnd%0d_s", k),     {16'd0, s_packed()}, {16'd0, exp_s});
            chk($sformatf("rnd%0d_swaps", k), {29'd0, swaps}, exp_inv);
            chk($sformatf("rnd%0d_eq", k),    {31'd0, eq_seen}, {31'd0, exp_dup});
            finish_pulse($sformatf("rnd%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sort4_ctrl.md
SORT4_CTRL -- requirements
Module: sort4_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; all data ports use it.
REQ-002 Parameter N, default 4, operand count; fixed at 4 in this revision.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset. Ports, in order: clk, rst_n.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request to sort a0..a3; sampled only in IDLE.
REQ-007 a0..a3  input  WIDTH each  unsigned operands; captured on the accepting edge.
REQ-008 s0..s3  output  WIDTH each  sorted result, ascending (s0 smallest).
REQ-009 busy  output  1  high while comparisons are in progress.
REQ-010 done  output  1  one-cycle pulse: s0..s3, swaps and eq_seen are valid.
REQ-011 swaps  output  3  number of exchanges performed, 0..6.
REQ-012 eq_seen  output  1  set if any comparison returned equal.

Function
REQ-013 The FSM SHALL have three states: IDLE, SORT and DONE.
REQ-014 IDLE with start=1 at edge E0: capture a0..a3 into work registers r0..r3, clear step/swap count/eq flag, go to SORT. busy=1 from E0.
REQ-015 SORT: one compare-exchange per cycle on one shared comparator. Pair order by step 0..5: (0,1),(1,2),(2,3),(0,1),(1,2),(0,1).
REQ-016 A step SHALL swap r[i] and r[i+1] at the clock edge only when the comparator g output is 1 (r[i] > r[i+1]). On e or l, no swap.
REQ-017 Each swap SHALL increment the swap count by 1. Any e=1 result SHALL set the eq flag.
REQ-018 After step 5 (edge E6): load s0..s3, swaps and eq_seen from the work registers and flags, go to DONE. busy=0 and done=1 for exactly one cycle.
REQ-019 DONE SHALL return to IDLE at the next edge (E7) unconditionally.
REQ-020 Fixed latency: done is high in the cycle after E6, i.e. 7 edges after the accepting edge.
REQ-021 start in SORT or DONE SHALL be ignored, with no queuing. a0..a3 changes after E0 SHALL NOT affect the result.
REQ-022 s0..s3, swaps and eq_seen SHALL hold their values from DONE until the next entry to DONE.
REQ-023 Equal operands SHALL never swap, so the sort is stable.
REQ-024 Comparison is unsigned. 4'b1111 vs 4'b0000 yields g=1; there is no wrap-around.

Reset
REQ-025 rst_n=0 SHALL immediately force: state IDLE, r0..r3=0, s0..s3=0, swaps=0, eq_seen=0, busy=0, done=0, step=0.
REQ-026 Reset asserted mid-SORT SHALL abort the sort with no done pulse. After release, the block SHALL accept start normally.
REQ-027 The first start SHALL be honoured on the first rising edge after rst_n deasserts.

Structure
REQ-028 A shared package SHALL hold WIDTH, N, NSTEPS=6, the state encoding, and the pair-index table for steps 0..5.
REQ-029 One sub-module SHALL be instantiated: magcom4bit (ports a, b, e, g, l), the existing 4-bit magnitude comparator, used as the single shared compare resource.
REQ-030 The comparator inputs SHALL be multiplexed from r[i] and r[i+1] by step. Its outputs are used combinationally in the same cycle.
REQ-031 All outputs SHALL be registered. There are no combinational paths from inputs to outputs.

Verification
REQ-032 a=(4,5,12,15), start -> done at edge 7; s=(4,5,12,15), swaps=0, eq_seen=0.
REQ-033 a=(14,13,6,7) -> s=(6,7,13,14), swaps=5, eq_seen=0.
REQ-034 a=(15,12,5,4) -> s=(4,5,12,15), swaps=6. Then a=(7,7,7,7) -> s=(7,7,7,7), swaps=0, eq_seen=1.
REQ-035 start held high through a whole sort, inputs changed at E2 -> exactly one done pulse, result from E0 inputs. A second sort begins only from IDLE after DONE.
REQ-036 rst_n pulsed low during step 3 -> all outputs 0 at once, no done. A new start of (14,13,6,7) after release -> s=(6,7,13,14).
REQ-037 A self-checking bench SHALL run 200 random operand sets against a reference sort and check swaps, eq_seen and latency=7.
